muldiv_unit: RTL and testbench

- Parametrised RV32M/RV64M multiply/divide execution unit that sits beside the ALU in the pipelined core's EX stage.
- Accepts one operation at a time through a start/busy/done handshake.
- Multiplies and divides iteratively over XLEN cycles; the hazard unit holds IF/ID/EX while the unit is busy.
- Returns a tagged result for write-back and supports flush (kill) from branch/jump resolution.

---
 rtl/muldiv_unit.sv | 174 +++++++++++++++++
 tb/tb_muldiv_unit.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Iterative RV32M/RV64M multiply/divide unit with start/busy/done handshake, tagged result and kill.
// Optional macro MULDIV_FAST_MUL_EN: single-cycle combinational multiplier; divides stay iterative.
module muldiv_unit #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [XLEN-1:0]  a,
    input  logic [XLEN-1:0]  b,
    input  logic [TAG_W-1:0] tag_in,
    input  logic             kill,
    output logic             busy,
    output logic             done,
    output logic [XLEN-1:0]  result,
    output logic [TAG_W-1:0] tag_out
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ITER  = 2'd1;
    localparam logic [1:0] S_FIXUP = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;
    localparam int CNT_W = $clog2(XLEN + 1);
    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    logic [1:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0]   opb_q, opb_d;
    logic [2:0]        op_q, op_d;
    logic              neg_q, neg_d;
    logic [TAG_W-1:0]  tag_q, tag_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic [TAG_W-1:0]  tag_out_q, tag_out_d;

    logic              is_div, a_signed, b_signed, neg_a, neg_b;
    logic [XLEN-1:0]   a_mag, b_mag;
    logic [XLEN:0]     mul_sum, div_sh, div_diff;
    logic [2*XLEN-1:0] mul_next, div_next, mul_full;
    logic [XLEN-1:0]   acc_lo, acc_hi;

    assign is_div   = op[2];
    assign a_signed = (op == 3'b001) || (op == 3'b010) || (op == 3'b100) || (op == 3'b110);
    assign b_signed = (op == 3'b001) || (op == 3'b100) || (op == 3'b110);
    assign neg_a    = a_signed & a[XLEN-1];
    assign neg_b    = b_signed & b[XLEN-1];
    assign a_mag    = neg_a ? -a : a;
    assign b_mag    = neg_b ? -b : b;

    // Multiply: acc = {partial product, remaining multiplier bits}, shifted right each step.
    assign mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opb_q} : '0);
    assign mul_next = {mul_sum, acc_q[XLEN-1:1]};

    // Divide: acc = {partial remainder, dividend bits shifting out / quotient bits shifting in}.
    assign div_sh   = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    assign div_diff = div_sh - {1'b0, opb_q};
    assign div_next = div_diff[XLEN] ? {div_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                                     : {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};

    assign acc_lo   = acc_q[XLEN-1:0];
    assign acc_hi   = acc_q[2*XLEN-1:XLEN];
    assign mul_full = neg_q ? -acc_q : acc_q;

`ifdef MULDIV_FAST_MUL_EN
    logic signed [2*XLEN-1:0] a_wide, b_wide;
    logic [2*XLEN-1:0]        fast_prod;
    assign a_wide    = {{XLEN{neg_a}}, a};
    assign b_wide    = {{XLEN{neg_b}}, b};
    assign fast_prod = a_wide * b_wide;
`endif

    always_comb begin
        // NOTE: every *_d defaults to its *_q so no path leaves a variable unassigned (no latches).
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        opb_d     = opb_q;
        op_d      = op_q;
        neg_d     = neg_q;
        tag_d     = tag_q;
        result_d  = result_q;
        tag_out_d = tag_out_q;

        case (state_q)
            S_ITER: begin
                if (kill) begin
                    state_d = S_IDLE;
                end else begin
                    acc_d = op_q[2] ? div_next : mul_next;
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) state_d = S_FIXUP;
                end
            end
            S_FIXUP: begin
                if (kill) begin
                    state_d = S_IDLE;
                end else begin
                    case (op_q)
                        3'b000:                 result_d = mul_full[XLEN-1:0];
                        3'b001, 3'b010, 3'b011: result_d = mul_full[2*XLEN-1:XLEN];
                        3'b100, 3'b101:         result_d = neg_q ? -acc_lo : acc_lo;
                        default:                result_d = neg_q ? -acc_hi : acc_hi;
                    endcase
                    tag_out_d = tag_q;
                    state_d   = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
                if (start && !kill) begin
                    op_d  = op;
                    tag_d = tag_in;
                    cnt_d = CNT_W'(XLEN);
                    // Remainder follows the dividend's sign; everything else follows the sign product.
                    neg_d = (is_div && op[1]) ? neg_a : (neg_a ^ neg_b);
                    if (is_div && b == '0) begin
                        result_d  = op[1] ? a : '1;
                        tag_out_d = tag_in;
                        state_d   = S_DONE;
                    end else if (is_div && !op[0] && a == MOST_NEG && b == '1) begin
                        result_d  = op[1] ? '0 : a;
                        tag_out_d = tag_in;
                        state_d   = S_DONE;
                    end else if (!is_div) begin
`ifdef MULDIV_FAST_MUL_EN
                        result_d  = (op == 3'b000) ? fast_prod[XLEN-1:0] : fast_prod[2*XLEN-1:XLEN];
                        tag_out_d = tag_in;
                        state_d   = S_DONE;
`else
                        acc_d   = {{XLEN{1'b0}}, b_mag};
                        opb_d   = a_mag;
                        state_d = S_ITER;
`endif
                    end else begin
                        acc_d   = {{XLEN{1'b0}}, a_mag};
                        opb_d   = b_mag;
                        state_d = S_ITER;
                    end
                end
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            opb_q     <= '0;
            op_q      <= '0;
            neg_q     <= 1'b0;
            tag_q     <= '0;
            result_q  <= '0;
            tag_out_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            opb_q     <= opb_d;
            op_q      <= op_d;
            neg_q     <= neg_d;
            tag_q     <= tag_d;
            result_q  <= result_d;
            tag_out_q <= tag_out_d;
        end
    end

    assign busy    = (state_q == S_ITER) || (state_q == S_FIXUP);
    assign done    = (state_q == S_DONE);
    assign result  = result_q;
    assign tag_out = tag_out_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit (XLEN=32): results, latency, special cases, kill, reset.
module tb_muldiv_unit;
    localparam int XLEN  = 32;
    localparam int TAG_W = 5;
`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = XLEN + 2;
`endif
    localparam int DIV_LAT = XLEN + 2;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             start = 1'b0;
    logic [2:0]       op = '0;
    logic [XLEN-1:0]  a = '0;
    logic [XLEN-1:0]  b = '0;
    logic [TAG_W-1:0] tag_in = '0;
    logic             kill = 1'b0;
    logic             busy, done;
    logic [XLEN-1:0]  result;
    logic [TAG_W-1:0] tag_out;

    int pass_cnt = 0;
    int total    = 0;

    muldiv_unit #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
        .tag_in(tag_in), .kill(kill), .busy(busy), .done(done),
        .result(result), .tag_out(tag_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    endtask

    // Drives a request now, lets the acceptance edge pass, then scrambles the inputs.
    task automatic launch(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                          input logic [4:0] t);
        start  = 1'b1;
        op     = o;
        a      = x;
        b      = y;
        tag_in = t;
        @(posedge clk);
        #1;
        start  = 1'b0;
        op     = 3'($urandom);
        a      = $urandom;
        b      = $urandom;
        tag_in = 5'($urandom);
    endtask

    // Called #1 after an edge; lat0 is how many edges since acceptance have already passed.
    task automatic wait_done(input string name, input int lat0, input int exp_lat,
                             input logic [31:0] exp_res, input logic [4:0] exp_tag);
        int lat = lat0;
        while (done !== 1'b1 && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({name, " latency"}, 64'(lat), 64'(exp_lat));
        check({name, " result"}, 64'(result), 64'(exp_res));
        check({name, " tag"}, 64'(tag_out), 64'(exp_tag));
        check({name, " busy in done"}, 64'(busy), 64'(0));
    endtask

    task automatic run_op(input string name, input logic [2:0] o, input logic [31:0] x,
                          input logic [31:0] y, input logic [4:0] t, input int exp_lat,
                          input logic [31:0] exp_res);
        @(posedge clk);
        #1;
        launch(o, x, y, t);
        check({name, " busy after accept"}, 64'(busy), 64'(exp_lat > 1));
        wait_done(name, 1, exp_lat, exp_res, t);
        @(posedge clk);
        #1;
        check({name, " done one cycle"}, 64'(done), 64'(0));
    endtask

    initial begin
        int dones;
        #1;
        check("reset busy", 64'(busy), 64'(0));
        check("reset done", 64'(done), 64'(0));
        check("reset result", 64'(result), 64'(0));
        check("reset tag", 64'(tag_out), 64'(0));
        repeat (2) @(negedge clk);
        rst = 1'b1;

        run_op("MUL 7*-3", 3'b000, 32'd7, 32'hFFFF_FFFD, 5'd1, MUL_LAT, 32'hFFFF_FFEB);
        run_op("MULHU", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, MUL_LAT, 32'hFFFF_FFFE);
        run_op("MULHSU", 3'b010, 32'hFFFF_FFFF, 32'd2, 5'd3, MUL_LAT, 32'hFFFF_FFFF);
        run_op("MULH", 3'b001, 32'h8000_0000, 32'h8000_0000, 5'd4, MUL_LAT, 32'h4000_0000);
        run_op("DIV -7/2", 3'b100, 32'hFFFF_FFF9, 32'd2, 5'd5, DIV_LAT, 32'hFFFF_FFFD);
        run_op("REM -7%2", 3'b110, 32'hFFFF_FFF9, 32'd2, 5'd6, DIV_LAT, 32'hFFFF_FFFF);
        run_op("DIVU 100/7", 3'b101, 32'd100, 32'd7, 5'd7, DIV_LAT, 32'd14);
        run_op("REMU 100%7", 3'b111, 32'd100, 32'd7, 5'd8, DIV_LAT, 32'd2);
        run_op("DIV 7/-2", 3'b100, 32'd7, 32'hFFFF_FFFE, 5'd9, DIV_LAT, 32'hFFFF_FFFD);
        run_op("REM 7%-2", 3'b110, 32'd7, 32'hFFFF_FFFE, 5'd10, DIV_LAT, 32'd1);
        run_op("DIVU by 0", 3'b101, 32'd55, 32'd0, 5'd11, 1, 32'hFFFF_FFFF);
        run_op("REM by 0", 3'b110, 32'h1234, 32'd0, 5'd12, 1, 32'h1234);
        run_op("DIV overflow", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 1, 32'h8000_0000);
        run_op("REM overflow", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 1, 32'd0);

        // A start while busy is dropped; the original operation completes untouched.
        @(posedge clk);
        #1;
        launch(3'b101, 32'd100, 32'd7, 5'd4);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        start  = 1'b1;
        op     = 3'b011;
        a      = 32'hFFFF_FFFF;
        b      = 32'hFFFF_FFFF;
        tag_in = 5'd9;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done("start while busy", 4, DIV_LAT, 32'd14, 5'd4);

        // Back-to-back: request issued in the done cycle.
        launch(3'b111, 32'd100, 32'd7, 5'd5);
        wait_done("back-to-back", 1, DIV_LAT, 32'd2, 5'd5);

        // Kill in cycle 10 of a DIV, together with a start that must not be accepted.
        @(posedge clk);
        #1;
        launch(3'b100, 32'd100, 32'd7, 5'd3);
        repeat (9) begin
            @(posedge clk);
            #1;
        end
        kill   = 1'b1;
        start  = 1'b1;
        op     = 3'b101;
        a      = 32'd50;
        b      = 32'd5;
        tag_in = 5'd7;
        @(posedge clk);
        #1;
        kill  = 1'b0;
        start = 1'b0;
        check("kill busy drop", 64'(busy), 64'(0));
        dones = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) dones++;
        end
        check("kill no done", 64'(dones), 64'(0));
        check("kill result kept", 64'(result), 64'(2));
        check("kill tag kept", 64'(tag_out), 64'(5));

        // Asynchronous reset in cycle 15 of a DIV.
        launch(3'b100, 32'd100, 32'd7, 5'd6);
        repeat (14) begin
            @(posedge clk);
            #1;
        end
        check("busy before reset", 64'(busy), 64'(1));
        #2;
        rst = 1'b0;
        #1;
        check("mid-op reset busy", 64'(busy), 64'(0));
        check("mid-op reset done", 64'(done), 64'(0));
        check("mid-op reset result", 64'(result), 64'(0));
        check("mid-op reset tag", 64'(tag_out), 64'(0));
        @(negedge clk);
        rst = 1'b1;
        run_op("MUL 3*5 after reset", 3'b000, 32'd3, 32'd5, 5'd2, MUL_LAT, 32'd15);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
